// File: rtl/boron_wrapper.sv
// BORON-style 64-bit block cipher with an 80-bit key, one round per clock.
// Define BORON_RESTART_EN to let a start during an encryption abort it and reload.
module boron_wrapper #(
  parameter int Key_Bit_Size     = 80,
  parameter int Number_of_Rounds = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [Key_Bit_Size-1:0] Key,
  input  logic [63:0]             Plain_Text,
  output logic [63:0]             Cipher_Text,
  output logic                    done,
  output logic                    busy
);

  if (Key_Bit_Size != 80) begin : g_key_size_check
    $error("boron_wrapper: Key_Bit_Size must be 80");
  end

  if (Number_of_Rounds < 2 || Number_of_Rounds > 31) begin : g_rounds_check
    $error("boron_wrapper: Number_of_Rounds must be in 2..31");
  end

  localparam logic [4:0]  last_round = 5'(Number_of_Rounds);
  // Nibble i of the table holds S(i).
  localparam logic [63:0] sbox_table = 64'h6358_F02D_AC97_1B4E;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      fsm;
  logic [4:0]  rc;
  logic [63:0] data;
  logic [79:0] k;
  logic [63:0] round_out;
  logic [79:0] key_next;
  logic        restart;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return sbox_table[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] boron_round(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] x;
    logic [63:0] y;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] w3;
    x = s ^ rk;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    w0 = {y[14:0],  y[15]};
    w1 = {y[27:16], y[31:28]};
    w2 = {y[40:32], y[47:41]};
    w3 = {y[54:48], y[63:55]};
    return {w3, w2 ^ w3, w1, w0 ^ w1};
  endfunction

  function automatic logic [79:0] key_schedule(input logic [79:0] kin, input logic [4:0] rnd);
    logic [79:0] kr;
    kr         = {kin[66:0], kin[79:67]};
    kr[3:0]    = sbox(kr[3:0]);
    kr[63:59]  = kr[63:59] ^ rnd;
    return kr;
  endfunction

  assign round_out = boron_round(data, k[63:0]);
  assign key_next  = key_schedule(k, rc);

`ifdef BORON_RESTART_EN
  assign restart = start;
`else
  assign restart = 1'b0;
`endif

  // Final edge of a run only whitens with RK_N; earlier edges apply a full round.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm         <= IDLE;
      rc          <= '0;
      data        <= '0;
      k           <= '0;
      Cipher_Text <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            data <= Plain_Text;
            k    <= 80'(Key);
            rc   <= 5'd1;
            busy <= 1'b1;
            fsm  <= RUN;
          end
        end
        RUN: begin
          if (restart) begin
            data <= Plain_Text;
            k    <= 80'(Key);
            rc   <= 5'd1;
          end else if (rc == last_round) begin
            Cipher_Text <= data ^ k[63:0];
            done        <= 1'b1;
            busy        <= 1'b0;
            rc          <= '0;
            fsm         <= IDLE;
          end else begin
            data <= round_out;
            k    <= key_next;
            rc   <= rc + 5'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boron_wrapper.sv
// Scoreboard bench for boron_wrapper: a 26-round instance plus a 2-round instance
// checked against a hand-computed vector.
module tb_boron_wrapper;

  typedef struct {
    logic [63:0] ct;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [79:0] key;
  logic [63:0] pt;
  logic [63:0] cipher;
  logic        done;
  logic        busy;

  logic        start2;
  logic [79:0] key2;
  logic [63:0] pt2;
  logic [63:0] cipher2;
  logic        done2;
  logic        busy2;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  logic [63:0] prev_ct;
  bit          prev_valid = 0;

  logic [3:0] sbox_tab [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  boron_wrapper #(.Key_Bit_Size(80), .Number_of_Rounds(26)) dut (
    .clk(clk), .reset(reset), .start(start), .Key(key), .Plain_Text(pt),
    .Cipher_Text(cipher), .done(done), .busy(busy)
  );

  boron_wrapper #(.Key_Bit_Size(80), .Number_of_Rounds(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .Key(key2), .Plain_Text(pt2),
    .Cipher_Text(cipher2), .done(done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] boron_model(input logic [79:0] key_in, input logic [63:0] pt_in,
                                              input int rounds);
    logic [79:0] kk;
    logic [63:0] s;
    logic [15:0] w [4];
    kk = key_in;
    s  = pt_in;
    for (int r = 1; r < rounds; r++) begin
      s = s ^ kk[63:0];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sbox_tab[s[4*j +: 4]];
      for (int j = 0; j < 4; j++) w[j] = s[16*j +: 16];
      w[0] = (w[0] << 1) | (w[0] >> 15);
      w[1] = (w[1] << 4) | (w[1] >> 12);
      w[2] = (w[2] << 7) | (w[2] >> 9);
      w[3] = (w[3] << 9) | (w[3] >> 7);
      w[0] = w[0] ^ w[1];
      w[2] = w[2] ^ w[3];
      s = {w[3], w[2], w[1], w[0]};
      kk = (kk << 13) | (kk >> 67);
      kk[3:0] = sbox_tab[kk[3:0]];
      kk[63:59] = kk[63:59] ^ 5'(r);
    end
    return s ^ kk[63:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor for the 26-round instance: every done pops one expected result.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (done && busy) begin
        errors++;
        $display("[TB] FAIL done_busy_overlap: got done=1 busy=1, expected not both");
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got ct=%h, expected no done", cipher);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("cipher", cipher, e.ct);
          checkOutput("done_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (prev_valid && cipher !== prev_ct) begin
        checks++;
        errors++;
        $display("[TB] FAIL ct_hold: got %h, expected %h (no done)", cipher, prev_ct);
      end
      prev_ct    = cipher;
      prev_valid = 1;
    end else begin
      prev_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (reset && done2) begin
      if (done2 && busy2) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_busy_overlap_n2: got done=1 busy=1, expected not both");
      end
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done_n2: got ct=%h, expected no done", cipher2);
      end else begin
        exp_t e;
        e = exp2_q.pop_front();
        checkOutput("cipher_n2", cipher2, e.ct);
        checkOutput("done_cycle_n2", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic applyStimulus(input logic [79:0] k_v, input logic [63:0] p_v);
    @(negedge clk);
    key   = k_v;
    pt    = p_v;
    start = 1'b1;
    exp_q.push_back('{ct: boron_model(k_v, p_v, 26), due: cyc + 1 + 26});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d pending results, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic runCountBusy(input string name, input logic [79:0] k_v, input logic [63:0] p_v);
    int bc;
    bc = 0;
    applyStimulus(k_v, p_v);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    checkOutput(name, 64'(bc), 64'd26);
    waitDrain(name, 10);
  endtask

  initial begin
    int unsigned e0;
    start  = 1'b0;
    key    = '0;
    pt     = '0;
    start2 = 1'b0;
    key2   = '0;
    pt2    = '0;
    reset  = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ct", cipher, 64'h0);
    checkOutput("reset_done", 64'(done), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    reset = 1'b1;

    // Hand-computed two-round vector.
    @(negedge clk);
    start2 = 1'b1;
    exp2_q.push_back('{ct: 64'hD5DD_AAAA_EEEE_333D, due: cyc + 1 + 2});
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("busy_n2", 64'(busy2), 64'h1);
    repeat (4) @(negedge clk);
    checkOutput("drain_n2", 64'(exp2_q.size()), 64'h0);
    checkOutput("idle_n2", 64'(busy2), 64'h0);

    runCountBusy("busy_cycles_zero", 80'h0, 64'h0);
    applyStimulus(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    waitDrain("ones", 40);
    applyStimulus(80'h0123_4567_89AB_CDEF_0123, 64'h0123_4567_89AB_CDEF);
    waitDrain("mixed", 40);

    // Inputs change while busy; the result must reflect the sampled values.
    applyStimulus(80'h8000_0000_0000_0000_0001, 64'hDEAD_BEEF_CAFE_F00D);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key = 80'({$urandom(), $urandom(), $urandom()});
      pt  = {$urandom(), $urandom()};
    end
    waitDrain("input_change", 40);

    // Reset in the middle of a run.
    applyStimulus(80'h1111_2222_3333_4444_5555, 64'h6666_7777_8888_9999);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrun_reset_ct", cipher, 64'h0);
    checkOutput("midrun_reset_busy", 64'(busy), 64'h0);
    checkOutput("midrun_reset_done", 64'(done), 64'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    runCountBusy("busy_cycles_after_reset", 80'h1111_2222_3333_4444_5555, 64'h6666_7777_8888_9999);

    // start held high: back-to-back runs every N+1 edges.
    @(negedge clk);
    key   = 80'hA5A5_5A5A_0F0F_F0F0_1234;
    pt    = 64'h0011_2233_4455_6677;
    start = 1'b1;
    e0    = cyc + 1;
    for (int j = 0; j < 3; j++)
      exp_q.push_back('{ct: boron_model(key, pt, 26), due: e0 + 27 * j + 26});
    for (int i = 0; i < 100 && cyc < e0 + 54; i++) begin
      @(negedge clk);
      if (cyc == e0 + 26) checkOutput("b2b_done", 64'(done), 64'h1);
      if (cyc == e0 + 27) checkOutput("b2b_busy_after_done", 64'(busy), 64'h1);
    end
    start = 1'b0;
    waitDrain("back_to_back", 80);

    // Second start in the middle of a run.
    applyStimulus(80'h0000_1111_0000_1111_0000, 64'h1234_5678_9ABC_DEF0);
    repeat (5) @(negedge clk);
    key   = 80'hFEDC_BA98_7654_3210_FEDC;
    pt    = 64'h0F1E_2D3C_4B5A_6978;
    start = 1'b1;
`ifdef BORON_RESTART_EN
    void'(exp_q.pop_back());
    exp_q.push_back('{ct: boron_model(key, pt, 26), due: cyc + 1 + 26});
`endif
    @(negedge clk);
    start = 1'b0;
    waitDrain("midrun_start", 60);
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
